sid_register_bank: RTL and testbench

- CPU-facing register file for one SID instance; it is the writer/reader end of the voice register interface.
- Accepts byte writes from the 6502-side bus and drives the 25 write-only registers consumed by the three sid_voice_8580 instances and the filter.
- Returns POTX, POTY, OSC3 and ENV3 on reads.
- Models SID data-bus decay: reads of write-only or unmapped addresses return the last bus value until it decays to zero.

---
 rtl/sid_register_bank.sv | 152 +++++++++++++++
 tb/tb_sid_register_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_register_bank.sv
// SID CPU-side register bank: 25 write-only voice/filter registers, the four
// readable registers (POTX, POTY, OSC3, ENV3), and the decaying data-bus latch
// that answers reads of write-only or unmapped addresses.
//
// Bus handshake: a request is the single cycle in which cs=1 is sampled at a
// rising clock edge. There is no ready; every request is accepted. we=1 is a
// write that takes effect at that edge. we=0 is a read: the result is
// captured at the request edge and presented on data_out together with a
// one-clock rd_valid pulse at the following edge. A reset in between drops
// the pending result, so no pulse follows a reset.
module sid_register_bank #(
  parameter int DECAY_CYCLES = 8192,
  parameter int DECAY_WIDTH  = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce_1m,
  input  logic         cs,
  input  logic         we,
  input  logic [4:0]   addr,
  input  logic [7:0]   data_in,
  output logic [7:0]   data_out,
  output logic         rd_valid,
  output logic [199:0] regs_out,
  input  logic [7:0]   potx,
  input  logic [7:0]   poty,
  input  logic [7:0]   osc3_in,
  input  logic [7:0]   env3_in
);

  localparam int NUM_REGS = 25;
  localparam logic [DECAY_WIDTH-1:0] RELOAD = DECAY_WIDTH'(DECAY_CYCLES);
  localparam logic [DECAY_WIDTH-1:0] ONE    = DECAY_WIDTH'(1);

  logic                   wr_en;
  logic                   rd_en;
  logic [7:0]             wr_masked;
  logic [7:0]             rd_value;
  logic                   rd_live;

  logic [7:0]             regs_q [NUM_REGS];
  logic [7:0]             latch_q, latch_d;
  logic [DECAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   pend_q;
  logic [7:0]             pend_data_q;
  logic [7:0]             data_out_q;
  logic                   rd_valid_q;

  assign wr_en = cs & we;
  assign rd_en = cs & ~we;

  // Storage mask: pulse-width high bytes keep 4 bits, filter cutoff low keeps 3.
  always_comb begin
    wr_masked = data_in;
    case (addr)
      5'h03, 5'h0A, 5'h11: wr_masked = {4'h0, data_in[3:0]};
      5'h15:               wr_masked = {5'h00, data_in[2:0]};
      default:             wr_masked = data_in;
    endcase
  end

  // Read mux: the four live registers, everything else answers from the bus latch.
  always_comb begin
    rd_value = latch_q;
    rd_live  = 1'b1;
    case (addr)
      5'h19:   rd_value = potx;
      5'h1A:   rd_value = poty;
      5'h1B:   rd_value = osc3_in;
      5'h1C:   rd_value = env3_in;
      default: begin
        rd_value = latch_q;
        rd_live  = 1'b0;
      end
    endcase
  end

  // Bus latch and decay: any bus drive reloads; otherwise ticks count down to a clear.
  always_comb begin
    latch_d = latch_q;
    cnt_d   = cnt_q;
    if (wr_en) begin
      latch_d = data_in;
      cnt_d   = RELOAD;
    end else if (rd_en && rd_live) begin
      latch_d = rd_value;
      cnt_d   = RELOAD;
    end else if (ce_1m && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
      if (cnt_q == ONE) begin
        latch_d = 8'h00;
      end
    end
  end

  // Write-only register storage; addresses past 0x18 match no register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (addr == 5'(i))) begin
          regs_q[i] <= wr_masked;
        end
      end
    end
  end

  // Bus latch and decay counter state.
  always_ff @(posedge clock) begin
    if (reset) begin
      latch_q <= 8'h00;
      cnt_q   <= '0;
    end else begin
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read pipeline: capture at the request edge, present one edge later.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
      data_out_q  <= 8'h00;
      rd_valid_q  <= 1'b0;
    end else begin
      pend_q     <= rd_en;
      rd_valid_q <= pend_q;
      if (rd_en) begin
        pend_data_q <= rd_value;
      end
      if (pend_q) begin
        data_out_q <= pend_data_q;
      end
    end
  end

  // Flatten the register array onto the voice/filter bus.
  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_out[8*i +: 8] = regs_q[i];
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sid_register_bank.sv
// Bench for sid_register_bank with a short decay window (16 ticks): directed
// vector table, hand-written decay/reset sequences, then random traffic, all
// compared against a behavioural model every cycle.
module tb_sid_register_bank;

  localparam int DECAY = 16;

  logic         clock;
  logic         reset;
  logic         ce_1m;
  logic         cs;
  logic         we;
  logic [4:0]   addr;
  logic [7:0]   data_in;
  logic [7:0]   data_out;
  logic         rd_valid;
  logic [199:0] regs_out;
  logic [7:0]   potx;
  logic [7:0]   poty;
  logic [7:0]   osc3_in;
  logic [7:0]   env3_in;

  int n_checks = 0;
  int n_pass   = 0;

  sid_register_bank #(
    .DECAY_CYCLES(DECAY),
    .DECAY_WIDTH (20)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ce_1m   (ce_1m),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .regs_out(regs_out),
    .potx    (potx),
    .poty    (poty),
    .osc3_in (osc3_in),
    .env3_in (env3_in)
  );

  // clock/reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural model ----------------
  logic [7:0] m_regs [25];
  logic [7:0] m_latch;
  int         m_left;
  bit         m_pend;
  bit         m_valid;
  logic [7:0] m_dout;
  logic [7:0] exp_q[$];

  task automatic model_edge();
    logic [7:0] v;
    bit reload;
    if (reset) begin
      for (int i = 0; i < 25; i++) m_regs[i] = 8'h00;
      m_latch = 8'h00;
      m_left  = 0;
      m_pend  = 0;
      m_valid = 0;
      m_dout  = 8'h00;
      exp_q.delete();
      return;
    end
    m_valid = m_pend;
    if (m_pend) m_dout = exp_q.pop_front();
    m_pend = cs && !we;
    reload = 0;
    if (cs && we) begin
      if (addr < 25) begin
        if (addr == 3 || addr == 10 || addr == 17) m_regs[addr] = data_in % 16;
        else if (addr == 21) m_regs[addr] = data_in % 8;
        else m_regs[addr] = data_in;
      end
      m_latch = data_in;
      reload  = 1;
    end else if (cs && !we) begin
      if (addr == 25) v = potx;
      else if (addr == 26) v = poty;
      else if (addr == 27) v = osc3_in;
      else if (addr == 28) v = env3_in;
      else v = m_latch;
      exp_q.push_back(v);
      if (addr >= 25 && addr <= 28) begin
        m_latch = v;
        reload  = 1;
      end
    end
    if (reload) m_left = DECAY;
    else if (ce_1m && m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_latch = 8'h00;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare_model();
    logic [199:0] exp_regs;
    for (int i = 0; i < 25; i++) exp_regs[8*i +: 8] = m_regs[i];
    check("model_regs_out", regs_out, exp_regs);
    check("model_rd_valid", 200'(rd_valid), 200'(m_valid));
    check("model_data_out", 200'(data_out), 200'(m_dout));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit c, input bit w, input logic [4:0] a,
                      input logic [7:0] d, input bit t);
    reset   = r;
    cs      = c;
    we      = w;
    addr    = a;
    data_in = d;
    ce_1m   = t;
    @(posedge clock);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle(input bit t);
    step(0, 0, 0, 5'h00, 8'h00, t);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst, c, w;
    logic [4:0] a;
    logic [7:0] d;
    bit         chk_rv, exp_rv, chk_dout;
    logic [7:0] exp_dout;
    int         byte_idx;
    logic [7:0] exp_byte;
  } vec_t;

  function automatic vec_t mk(bit rst, bit c, bit w, logic [4:0] a, logic [7:0] d,
                              bit chk_rv, bit exp_rv, bit chk_dout, logic [7:0] exp_dout,
                              int byte_idx, logic [7:0] exp_byte);
    vec_t v;
    v.rst = rst; v.c = c; v.w = w; v.a = a; v.d = d;
    v.chk_rv = chk_rv; v.exp_rv = exp_rv; v.chk_dout = chk_dout; v.exp_dout = exp_dout;
    v.byte_idx = byte_idx; v.exp_byte = exp_byte;
    return v;
  endfunction

  vec_t vecs[$];

  task automatic expect_read(input string name, input logic [7:0] exp);
    check({name, "_rv"}, 200'(rd_valid), 200'(1'b1));
    check({name, "_dout"}, 200'(data_out), 200'(exp));
  endtask

  initial begin
    potx = 8'h00; poty = 8'h00; osc3_in = 8'h5A; env3_in = 8'hC3;

    vecs.push_back(mk(1, 0, 0, 5'h00, 8'h00, 1, 0, 1, 8'h00, 0,  8'h00));
    vecs.push_back(mk(1, 1, 0, 5'h19, 8'h00, 1, 0, 1, 8'h00, 1,  8'h00));
    vecs.push_back(mk(0, 1, 1, 5'h00, 8'h1F, 0, 0, 0, 8'h00, 0,  8'h1F));
    vecs.push_back(mk(0, 1, 1, 5'h01, 8'h25, 0, 0, 0, 8'h00, 1,  8'h25));
    vecs.push_back(mk(0, 1, 1, 5'h15, 8'hFF, 0, 0, 0, 8'h00, 21, 8'h07));
    vecs.push_back(mk(0, 1, 1, 5'h03, 8'hAB, 0, 0, 0, 8'h00, 3,  8'h0B));
    vecs.push_back(mk(0, 1, 0, 5'h03, 8'h00, 1, 0, 0, 8'h00, -1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 1, 1, 1, 8'hAB, -1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 1, 0, 1, 8'hAB, -1, 8'h00));
    vecs.push_back(mk(0, 1, 0, 5'h1B, 8'h00, 1, 0, 0, 8'h00, -1, 8'h00));
    vecs.push_back(mk(0, 1, 0, 5'h1C, 8'h00, 1, 1, 1, 8'h5A, -1, 8'h00));
    vecs.push_back(mk(0, 1, 0, 5'h1D, 8'h00, 1, 1, 1, 8'hC3, -1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 1, 1, 1, 8'hC3, 2,  8'h00));
    vecs.push_back(mk(0, 1, 1, 5'h1A, 8'h99, 1, 0, 1, 8'hC3, 0,  8'h1F));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].c, vecs[k].w, vecs[k].a, vecs[k].d, 1'b0);
      if (vecs[k].chk_rv) check($sformatf("vec%0d_rd_valid", k), 200'(rd_valid), 200'(vecs[k].exp_rv));
      if (vecs[k].chk_dout) check($sformatf("vec%0d_data_out", k), 200'(data_out), 200'(vecs[k].exp_dout));
      if (vecs[k].byte_idx >= 0)
        check($sformatf("vec%0d_byte%0d", k, vecs[k].byte_idx),
              200'(regs_out[8*vecs[k].byte_idx +: 8]), 200'(vecs[k].exp_byte));
    end

    // Decay: latch survives 15 ticks, clears on the 16th.
    step(0, 1, 1, 5'h04, 8'h77, 0);
    repeat (15) idle(1);
    step(0, 1, 0, 5'h1E, 8'h00, 0);
    idle(0);
    expect_read("decay_15", 8'h77);
    idle(1);
    step(0, 1, 0, 5'h1E, 8'h00, 0);
    idle(0);
    expect_read("decay_16", 8'h00);

    // Reload coincident with the 16th tick wins: full window restarts.
    step(0, 1, 1, 5'h04, 8'h77, 0);
    repeat (15) idle(1);
    step(0, 1, 1, 5'h05, 8'h88, 1);
    step(0, 1, 0, 5'h1E, 8'h00, 0);
    idle(0);
    expect_read("reload_tick", 8'h88);
    repeat (15) idle(1);
    step(0, 1, 0, 5'h1F, 8'h00, 0);
    idle(0);
    expect_read("reload_15", 8'h88);
    idle(1);
    step(0, 1, 0, 5'h1F, 8'h00, 0);
    idle(0);
    expect_read("reload_16", 8'h00);

    // Reset the cycle after a read request: no pulse, everything cleared.
    step(0, 1, 1, 5'h05, 8'h12, 0);
    step(0, 1, 0, 5'h1B, 8'h00, 0);
    step(1, 0, 0, 5'h00, 8'h00, 0);
    check("rst_mid_rv", 200'(rd_valid), 200'(1'b0));
    check("rst_mid_dout", 200'(data_out), 200'(8'h00));
    idle(0);
    check("rst_mid_rv_after", 200'(rd_valid), 200'(1'b0));
    check("rst_mid_regs", regs_out, 200'(0));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      potx    = 8'($urandom);
      poty    = 8'($urandom);
      osc3_in = 8'($urandom);
      env3_in = 8'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
           5'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
